adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one registered 26-bit adder datapath between NREQ requesters using round-robin arbitration.
- The adder datapath has a registered input stage and a registered output stage, and sits outside this block on the add_* ports.
- The block arbitrates requests, drives the operands, and tracks the in-flight requester tag through the adder latency.
- It returns each 27-bit sum to the owning requester through a one-entry result buffer with a valid/ready handshake.

Parameters:
- W, 26, operand width; the sum is W+1 bits.
- NREQ, 2, number of requesters; legal range 2..4.
- LAT, 2, clock edges from operand capture in the adder input register to the sum being stable on add_sum, plus one edge.

Ports:
- clk  input  1  single clock; all state updates on the falling edge, matching the adder's registers.
- reset  input  1  synchronous, active-high.
- req_valid  input  NREQ  request valid, one bit per requester.
- req_ready  output  NREQ  request accepted this cycle (one-hot or zero).
- req_a  input  NREQ*W  packed operand A; slice i belongs to requester i.
- req_b  input  NREQ*W  packed operand B.
- resp_valid  output  NREQ  result buffer i holds a sum.
- resp_ready  input  NREQ  requester i consumes its result.
- resp_sum  output  NREQ*(W+1)  packed result buffers.
- add_a  output  W  operand A to the adder datapath.
- add_b  output  W  operand B to the adder datapath.
- add_sum  input  W+1  registered sum from the adder datapath.
- add_issue  output  1  an operation is issued this cycle (observability).

Behaviour:
- Per-requester state, 2 bits: IDLE, INFLIGHT, DONE.
  - IDLE -> INFLIGHT on accept.
  - INFLIGHT -> DONE on capture of add_sum.
  - DONE -> IDLE on resp_valid & resp_ready.
- Eligibility: requester i is eligible when req_valid[i] is high and state[i] is IDLE. Each requester has at most one operation outstanding.
- Grant: combinational round robin over eligible requesters.
  - Search starts at rr_ptr+1 (mod NREQ).
  - req_ready[i] is high only for the granted requester.
  - The handshake occurs when req_valid[i] & req_ready[i] are high at the edge.
- rr_ptr updates to the granted index only on accept and holds otherwise. Reset value: NREQ-1, so requester 0 has first priority.
- add_a/add_b: combinationally muxed from the granted requester's slices; zero when there is no grant. add_issue equals OR of req_ready.
- Tag pipeline: LAT stages, each holding {vld, id}.
  - Stage 0 loads {add_issue, grant id} every edge; each later stage shifts every edge.
  - When the last stage is valid, add_sum is latched into resp_sum slice [id] at the next edge, and state[id] goes to DONE.
- Latency: request accepted at edge k -> resp_valid[i] high after edge k+LAT (default 2). Throughput is one issue per cycle across requesters.
- resp_valid[i] equals (state[i]==DONE). resp_sum slice i is held stable while DONE and keeps its last value when IDLE.
- Simultaneous events:
  - The same requester cannot complete and be re-accepted in one cycle; it must be IDLE to be granted.
  - A consume (DONE->IDLE) and a new request from the same requester in the same cycle: not granted until the next cycle, because eligibility uses the registered state.
- Arithmetic: none inside the block. add_sum is passed through unmodified at W+1 bits. The adder datapath carries no carry-in.
- Reset, including mid-operation:
  - All states go to IDLE; every tag-pipeline vld clears; rr_ptr goes to NREQ-1.
  - resp_valid=0, req_ready=0, add_issue=0, resp_sum=0.
  - add_sum values for operations issued before reset are discarded because their tags were cleared.
  - During reset, req_ready is forced 0 even when requests are valid.
- Requesters must hold req_a/req_b/req_valid stable until accepted. This is not checked by the block.

Decomposition:
- Shared package: state encodings (ST_IDLE=2'd0, ST_INFLIGHT=2'd1, ST_DONE=2'd2) and default widths W=26, SUM_W=27.
- One natural sub-module: rr_arbiter. It takes NREQ eligible bits and rr_ptr, and outputs a one-hot grant plus an index; it is purely combinational.
- The tag pipeline and result buffers stay in the top module.
- The bench wraps this block together with the existing registered 26-bit adder. Its input/output flops are clocked on the falling edge of clk with synchronous reset, which gives LAT=2.

Test Plan:
- Single request: req 0 with a=26'h3FFFFFF, b=26'h0000001 -> resp_valid[0] high exactly 2 edges after accept, resp_sum[0]=27'h4000000. Hold resp_ready low 5 cycles -> value stable; state is DONE, so req 0 is not re-granted.
- Contention: both requesters valid continuously with resp_ready=1 -> grants alternate 0,1,0,1. Sums 1+2=27'h3 and 5+6=27'hB return to the correct slices; issue to completion is 2 edges each.
- Back-to-back issue: req 0 (a=10, b=20) at edge k and req 1 (a=30, b=40) at edge k+1 -> resp_valid[0] after k+2 with 30, resp_valid[1] after k+3 with 70, with no tag mix-up.
- Backpressure: req 1 DONE with resp_ready[1]=0 while req 0 keeps issuing -> req 1 never granted and req 0 served every eligible cycle. Releasing resp_ready[1] frees req 1, which is granted the following cycle.
- Reset mid-flight: accept req 0 then assert reset for 1 edge before completion -> all outputs 0. The stale add_sum does not set resp_valid, and the first post-reset grant goes to requester 0.
- Overflow boundary: a=b=26'h3FFFFFF -> resp_sum=27'h7FFFFFE, with the full W+1 width preserved.

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and default widths for the shared-adder arbiter.
// Requester state encodings and an index-width helper used by the top and arbiter.
package adder_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INFLIGHT = 2'd1,
    ST_DONE     = 2'd2
  } req_state_e;

  localparam int ADD_W     = 26;
  localparam int ADD_SUM_W = ADD_W + 1;

  // A single requester still needs a 1-bit index so that port widths stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past rr_ptr and wraps.
// Returns a one-hot grant, its index and a valid flag.
module rr_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDXW-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  logic [IDXW-1:0] cand;

  // The first eligible candidate in rotated order wins; later hits are ignored.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDXW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one external registered adder between NREQ requesters, tracks in-flight tags,
// and returns each sum through a per-requester one-entry buffer.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int W    = ADD_W,
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*W-1:0]     req_a,
  input  logic [NREQ*W-1:0]     req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [NREQ*(W+1)-1:0] resp_sum,
  output logic [W-1:0]          add_a,
  output logic [W-1:0]          add_b,
  input  logic [W:0]            add_sum,
  output logic                  add_issue
);

  localparam int IDXW = idx_width(NREQ);

  req_state_e                state     [NREQ];
  req_state_e                state_nxt [NREQ];
  logic [NREQ-1:0]           eligible;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           capture;
  logic [IDXW-1:0]           grant_idx;
  logic [IDXW-1:0]           rr_ptr;
  logic                      grant_valid;
  logic [LAT-1:0]            tag_vld;
  logic [LAT-1:0][IDXW-1:0]  tag_id;
  logic [NREQ-1:0][W:0]      sum_buf;

  // Eligibility uses the registered state, so a consume and a new request in the same cycle
  // only become grantable on the following cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = !reset && req_valid[i] && (state[i] == ST_IDLE);
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_arbiter (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;
  assign add_issue = grant_valid;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (grant_valid) begin
      add_a = req_a[int'(grant_idx)*W +: W];
      add_b = req_b[int'(grant_idx)*W +: W];
    end
  end

  // The last tag stage names the requester whose sum is currently on add_sum.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_nxt[i] = state[i];
      capture[i]   = tag_vld[LAT-1] && (tag_id[LAT-1] == IDXW'(i));
      case (state[i])
        ST_IDLE:     if (grant[i])      state_nxt[i] = ST_INFLIGHT;
        ST_INFLIGHT: if (capture[i])    state_nxt[i] = ST_DONE;
        ST_DONE:     if (resp_ready[i]) state_nxt[i] = ST_IDLE;
        default:                        state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  // Falling edge, so that tags stay aligned with the adder's own input/output registers.
  always_ff @(negedge clk) begin
    if (reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
      rr_ptr  <= IDXW'(NREQ - 1);
      sum_buf <= '0;
      for (int i = 0; i < NREQ; i++) state[i] <= ST_IDLE;
    end else begin
      tag_vld[0] <= grant_valid;
      tag_id[0]  <= grant_idx;
      for (int s = 1; s < LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
      if (grant_valid) rr_ptr <= grant_idx;
      for (int i = 0; i < NREQ; i++) begin
        state[i] <= state_nxt[i];
        if ((state[i] == ST_INFLIGHT) && capture[i]) sum_buf[i] <= add_sum;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) resp_valid[i] = (state[i] == ST_DONE);
  end

  assign resp_sum = sum_buf;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench: shared arbiter plus a falling-edge registered adder, checked every cycle against
// a cycle-count behavioural model, with directed scenarios pinned by literal sums/grants.
module tb_adder_share_arbiter;

  localparam int W    = 26;
  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int SW   = W + 1;

  logic                 clk = 1'b1;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a = '0;
  logic [NREQ*W-1:0]    req_b = '0;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready = '0;
  logic [NREQ*SW-1:0]   resp_sum;
  logic [W-1:0]         add_a;
  logic [W-1:0]         add_b;
  logic [W:0]           add_sum;
  logic                 add_issue;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.W(W), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .add_issue  (add_issue)
  );

  // Existing registered adder: input and output flops on the falling edge, synchronous reset.
  logic [W-1:0] adder_ia, adder_ib;
  logic [W:0]   adder_q;
  always @(negedge clk) begin
    if (reset) begin
      adder_ia <= '0;
      adder_ib <= '0;
      adder_q  <= '0;
    end else begin
      adder_ia <= add_a;
      adder_ib <= add_b;
      adder_q  <= {1'b0, adder_ia} + {1'b0, adder_ib};
    end
  end
  assign add_sum = adder_q;

  // Behavioural model: each requester is idle, busy with a countdown, or done holding a sum.
  bit              mdl_busy [NREQ];
  bit              mdl_done [NREQ];
  int              mdl_left [NREQ];
  logic [W:0]      mdl_pend [NREQ];
  logic [W:0]      mdl_sum  [NREQ];
  int              mdl_ptr = NREQ - 1;
  logic [NREQ-1:0] mdl_acc = '0;
  bit              mdl_armed = 1'b0;

  function automatic int predGrant();
    int c;
    if (reset) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      c = (mdl_ptr + k) % NREQ;
      if (req_valid[c] && !mdl_busy[c] && !mdl_done[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    int g;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < NREQ; i++) begin
          mdl_busy[i] = 1'b0;
          mdl_done[i] = 1'b0;
          mdl_left[i] = 0;
          mdl_pend[i] = '0;
          mdl_sum[i]  = '0;
        end
        mdl_ptr = NREQ - 1;
        mdl_acc = '0;
      end else begin
        g = predGrant();
        mdl_acc = '0;
        for (int i = 0; i < NREQ; i++) begin
          if (mdl_done[i]) begin
            if (resp_ready[i]) mdl_done[i] = 1'b0;
          end else if (mdl_busy[i]) begin
            mdl_left[i]--;
            if (mdl_left[i] == 0) begin
              mdl_busy[i] = 1'b0;
              mdl_done[i] = 1'b1;
              mdl_sum[i]  = mdl_pend[i];
            end
          end
        end
        if (g >= 0) begin
          mdl_busy[g] = 1'b1;
          mdl_left[g] = LAT;
          mdl_pend[g] = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
          mdl_ptr     = g;
          mdl_acc[g]  = 1'b1;
        end
      end
      mdl_armed = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison on the rising edge, half a period away from the active edge.
  initial begin
    int g;
    logic [NREQ-1:0]    er, ev;
    logic [W-1:0]       ea, eb;
    logic [NREQ*SW-1:0] es;
    forever begin
      @(posedge clk);
      if (mdl_armed) begin
        g  = predGrant();
        er = '0;
        ea = '0;
        eb = '0;
        if (g >= 0) begin
          er[g] = 1'b1;
          ea    = req_a[g*W +: W];
          eb    = req_b[g*W +: W];
        end
        for (int i = 0; i < NREQ; i++) begin
          ev[i]          = mdl_done[i];
          es[i*SW +: SW] = mdl_sum[i];
        end
        checkOutput("cyc_req_ready",  64'(req_ready),  64'(er));
        checkOutput("cyc_add_issue",  64'(add_issue),  64'(|er));
        checkOutput("cyc_add_ab",     {12'd0, add_a, add_b}, {12'd0, ea, eb});
        checkOutput("cyc_resp_valid", 64'(resp_valid), 64'(ev));
        checkOutput("cyc_resp_sum",   64'(resp_sum),   64'(es));
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr,
                               input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [W-1:0] a1, input logic [W-1:0] b1);
    reset      = rst;
    req_valid  = v;
    resp_ready = rr;
    req_a      = {a1, a0};
    req_b      = {b1, b0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NREQ-1:0] seen [4];
    int ng;

    // Reset with both requests valid: nothing may be granted.
    applyStimulus(1'b1, 2'b11, 2'b00, 26'd1, 26'd2, 26'd3, 26'd4);
    step(); step();
    #1;
    checkOutput("reset_req_ready",  64'(req_ready),  64'd0);
    checkOutput("reset_add_issue",  64'(add_issue),  64'd0);
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset_resp_sum",   64'(resp_sum),   64'd0);

    // Single request with carry into bit W, then hold the result under backpressure.
    applyStimulus(1'b0, 2'b01, 2'b00, 26'h3FFFFFF, 26'h0000001, 26'd0, 26'd0);
    #1 checkOutput("single_grant", 64'(req_ready), 64'b01);
    step();
    applyStimulus(1'b0, 2'b00, 2'b00, 26'h3FFFFFF, 26'h0000001, 26'd0, 26'd0);
    #1 checkOutput("single_lat1", 64'(resp_valid), 64'b00);
    step();
    #1 checkOutput("single_lat2", 64'(resp_valid), 64'b00);
    step();
    #1 checkOutput("single_valid", 64'(resp_valid), 64'b01);
    checkOutput("single_sum", 64'(resp_sum[SW-1:0]), 64'h4000000);
    applyStimulus(1'b0, 2'b01, 2'b00, 26'h3FFFFFF, 26'h0000001, 26'd0, 26'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("hold_no_regrant", 64'(req_ready), 64'b00);
      checkOutput("hold_sum", 64'(resp_sum[SW-1:0]), 64'h4000000);
      step();
    end
    applyStimulus(1'b0, 2'b00, 2'b01, 26'd0, 26'd0, 26'd0, 26'd0);
    step();
    #1 checkOutput("single_consumed", 64'(resp_valid), 64'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 26'd0, 26'd0, 26'd0, 26'd0);

    // Overflow boundary keeps the full W+1 bits.
    applyStimulus(1'b0, 2'b01, 2'b00, 26'h3FFFFFF, 26'h3FFFFFF, 26'd0, 26'd0);
    step();
    applyStimulus(1'b0, 2'b00, 2'b00, 26'h3FFFFFF, 26'h3FFFFFF, 26'd0, 26'd0);
    step(); step();
    #1 checkOutput("ovf_valid", 64'(resp_valid), 64'b01);
    checkOutput("ovf_sum", 64'(resp_sum[SW-1:0]), 64'h7FFFFFE);
    applyStimulus(1'b0, 2'b00, 2'b01, 26'd0, 26'd0, 26'd0, 26'd0);
    step();
    applyStimulus(1'b0, 2'b00, 2'b00, 26'd0, 26'd0, 26'd0, 26'd0);

    // Back-to-back issue from different requesters.
    applyStimulus(1'b0, 2'b01, 2'b00, 26'd10, 26'd20, 26'd30, 26'd40);
    #1 checkOutput("b2b_grant0", 64'(req_ready), 64'b01);
    step();
    applyStimulus(1'b0, 2'b10, 2'b00, 26'd10, 26'd20, 26'd30, 26'd40);
    #1 checkOutput("b2b_grant1", 64'(req_ready), 64'b10);
    step();
    applyStimulus(1'b0, 2'b00, 2'b00, 26'd10, 26'd20, 26'd30, 26'd40);
    #1 checkOutput("b2b_none_yet", 64'(resp_valid), 64'b00);
    step();
    #1 checkOutput("b2b_valid0", 64'(resp_valid), 64'b01);
    checkOutput("b2b_sum0", 64'(resp_sum[SW-1:0]), 64'd30);
    step();
    #1 checkOutput("b2b_valid1", 64'(resp_valid), 64'b11);
    checkOutput("b2b_sum1", 64'(resp_sum[2*SW-1:SW]), 64'd70);
    checkOutput("b2b_sum0_kept", 64'(resp_sum[SW-1:0]), 64'd30);
    applyStimulus(1'b0, 2'b00, 2'b11, 26'd0, 26'd0, 26'd0, 26'd0);
    step();
    #1 checkOutput("b2b_consumed", 64'(resp_valid), 64'b00);

    // Contention: grants must alternate between the two requesters.
    applyStimulus(1'b0, 2'b11, 2'b11, 26'd1, 26'd2, 26'd5, 26'd6);
    ng = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (req_ready != '0 && ng < 4) begin
        seen[ng] = req_ready;
        ng++;
      end
      if (resp_valid[0]) checkOutput("cont_sum0", 64'(resp_sum[SW-1:0]), 64'h3);
      if (resp_valid[1]) checkOutput("cont_sum1", 64'(resp_sum[2*SW-1:SW]), 64'hB);
      step();
    end
    checkOutput("cont_grant_count", 64'(ng), 64'd4);
    checkOutput("cont_order", {56'd0, seen[0], seen[1], seen[2], seen[3]}, {56'd0, 8'b01_10_01_10});
    applyStimulus(1'b0, 2'b00, 2'b11, 26'd0, 26'd0, 26'd0, 26'd0);
    for (int c = 0; c < 4; c++) step();

    // Backpressure: requester 1 parked in DONE, requester 0 keeps issuing.
    applyStimulus(1'b0, 2'b10, 2'b01, 26'd0, 26'd0, 26'd7, 26'd9);
    step();
    applyStimulus(1'b0, 2'b00, 2'b01, 26'd0, 26'd0, 26'd7, 26'd9);
    step(); step();
    applyStimulus(1'b0, 2'b11, 2'b01, 26'd3, 26'd4, 26'd7, 26'd9);
    for (int c = 0; c < 10; c++) begin
      #1 checkOutput("bp_no_grant1", 64'(req_ready[1]), 64'd0);
      step();
    end
    applyStimulus(1'b0, 2'b11, 2'b11, 26'd3, 26'd4, 26'd7, 26'd9);
    step();
    #1 checkOutput("bp_release_grant", 64'(req_ready), 64'b10);
    applyStimulus(1'b0, 2'b00, 2'b11, 26'd0, 26'd0, 26'd0, 26'd0);
    for (int c = 0; c < 4; c++) step();

    // Reset mid-flight: the stale sum must not complete and requester 0 gets first grant.
    applyStimulus(1'b0, 2'b01, 2'b00, 26'd7, 26'd8, 26'd0, 26'd0);
    step();
    applyStimulus(1'b1, 2'b11, 2'b00, 26'd7, 26'd8, 26'd5, 26'd5);
    #1 checkOutput("rst_req_ready", 64'(req_ready), 64'b00);
    checkOutput("rst_add_issue", 64'(add_issue), 64'd0);
    step();
    applyStimulus(1'b0, 2'b00, 2'b00, 26'd0, 26'd0, 26'd0, 26'd0);
    #1 checkOutput("rst_resp_valid", 64'(resp_valid), 64'b00);
    checkOutput("rst_resp_sum", 64'(resp_sum), 64'd0);
    step();
    #1 checkOutput("rst_stale1", 64'(resp_valid), 64'b00);
    step();
    #1 checkOutput("rst_stale2", 64'(resp_valid), 64'b00);
    applyStimulus(1'b0, 2'b11, 2'b00, 26'd1, 26'd1, 26'd2, 26'd2);
    #1 checkOutput("rst_first_grant", 64'(req_ready), 64'b01);
    applyStimulus(1'b0, 2'b00, 2'b00, 26'd0, 26'd0, 26'd0, 26'd0);
    step();

    // Random traffic: requests held until accepted, random backpressure and occasional reset.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && mdl_acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i]     = 1'b1;
          req_a[i*W +: W]  = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
          req_b[i*W +: W]  = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
        end
        resp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    applyStimulus(1'b0, 2'b00, 2'b11, 26'd0, 26'd0, 26'd0, 26'd0);
    for (int c = 0; c < 4; c++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
